// File: rtl/nasti_lite_read_arbiter_if.sv
// NASTI-lite read bundle (AR + R channels) carrying N lanes side by side.
// Lane i of every field occupies [i*W +: W].
//
// Modports:
//   master : drives AR requests and R ready, receives AR ready and R beats
//   slave  : receives AR requests and R ready, drives AR ready and R beats
interface nasti_lite_read_arbiter_if #(
    parameter int N          = 1,
    parameter int ID_WIDTH   = 1,
    parameter int ADDR_WIDTH = 12,
    parameter int DATA_WIDTH = 32,
    parameter int USER_WIDTH = 1
);
    logic [N*ID_WIDTH-1:0]   ar_id;
    logic [N*ADDR_WIDTH-1:0] ar_addr;
    logic [N*3-1:0]          ar_prot;
    logic [N*4-1:0]          ar_qos;
    logic [N*4-1:0]          ar_region;
    logic [N*USER_WIDTH-1:0] ar_user;
    logic [N-1:0]            ar_valid;
    logic [N-1:0]            ar_ready;

    logic [N*ID_WIDTH-1:0]   r_id;
    logic [N*DATA_WIDTH-1:0] r_data;
    logic [N*2-1:0]          r_resp;
    logic [N*USER_WIDTH-1:0] r_user;
    logic [N-1:0]            r_valid;
    logic [N-1:0]            r_ready;

    modport master (
        output ar_id, ar_addr, ar_prot, ar_qos, ar_region, ar_user, ar_valid, r_ready,
        input  ar_ready, r_id, r_data, r_resp, r_user, r_valid
    );

    modport slave (
        input  ar_id, ar_addr, ar_prot, ar_qos, ar_region, ar_user, ar_valid, r_ready,
        output ar_ready, r_id, r_data, r_resp, r_user, r_valid
    );
endinterface

// File: rtl/nasti_lite_read_arbiter.sv
// Round-robin arbiter sharing one NASTI-lite read port between N_MASTER
// requesters. Grant order is kept in an order FIFO so that the in-order R
// beats of the lite slave are steered back to the master that issued the AR.
//
// Ports:
//   clk  : clock, rising edge
//   rstn : asynchronous active-low reset
//   m    : N_MASTER-lane read bundle facing the requesters (slave modport)
//   s    : single-lane read bundle facing the lite slave (master modport)
//
// state | meaning
// ------+-----------------------------------------------------------------
// IDLE  | no grant held; arbitrate when a request is present and FIFO has room
// GRANT | r_gnt owns the slave AR channel until its AR handshake completes
module nasti_lite_read_arbiter #(
    parameter int N_MASTER        = 2,
    parameter int MAX_TRANSACTION = 2,
    parameter int ID_WIDTH        = 1,
    parameter int ADDR_WIDTH      = 12,
    parameter int DATA_WIDTH      = 32,
    parameter int USER_WIDTH      = 1
) (
    input  logic                        clk,
    input  logic                        rstn,
    nasti_lite_read_arbiter_if.slave    m,
    nasti_lite_read_arbiter_if.master   s
);
    localparam int IDX_W = (N_MASTER > 1) ? $clog2(N_MASTER) : 1;
    localparam int PTR_W = (MAX_TRANSACTION > 1) ? $clog2(MAX_TRANSACTION) : 1;
    localparam int CNT_W = $clog2(MAX_TRANSACTION + 1);

    typedef enum logic {IDLE, GRANT} state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [IDX_W-1:0]   r_gnt;
    logic [IDX_W-1:0]   w_gnt_nxt;
    logic [IDX_W-1:0]   r_rr_ptr;
    logic [IDX_W-1:0]   w_rr_nxt;

    logic [IDX_W-1:0]   r_fifo [MAX_TRANSACTION];
    logic [PTR_W-1:0]   r_wr_ptr;
    logic [PTR_W-1:0]   r_rd_ptr;
    logic [CNT_W-1:0]   r_count;

    logic               w_any;
    logic [IDX_W-1:0]   w_pick;
    logic               w_full;
    logic               w_empty;
    logic [IDX_W-1:0]   w_head;
    logic [IDX_W-1:0]   w_ar_sel;
    logic               w_ar_hs;
    logic               w_push;
    logic               w_pop;

    assign w_full  = (r_count == CNT_W'(MAX_TRANSACTION));
    assign w_empty = (r_count == '0);
    assign w_head  = r_fifo[r_rd_ptr];

    // First requester at or after rr_ptr; scanning downwards lets the
    // lowest rotation offset win.
    always_comb begin
        int idx;
        w_any  = 1'b0;
        w_pick = '0;
        idx    = 0;
        for (int k = N_MASTER - 1; k >= 0; k--) begin
            idx = (int'(r_rr_ptr) + k) % N_MASTER;
            if (m.ar_valid[IDX_W'(idx)]) begin
                w_any  = 1'b1;
                w_pick = IDX_W'(idx);
            end
        end
    end

    // ---------------- AR channel ----------------
    // Outside GRANT the payload is a don't-care and simply follows master 0.
    assign w_ar_sel    = (r_state == GRANT) ? r_gnt : '0;
    assign s.ar_id     = m.ar_id    [int'(w_ar_sel)*ID_WIDTH   +: ID_WIDTH];
    assign s.ar_addr   = m.ar_addr  [int'(w_ar_sel)*ADDR_WIDTH +: ADDR_WIDTH];
    assign s.ar_prot   = m.ar_prot  [int'(w_ar_sel)*3          +: 3];
    assign s.ar_qos    = m.ar_qos   [int'(w_ar_sel)*4          +: 4];
    assign s.ar_region = m.ar_region[int'(w_ar_sel)*4          +: 4];
    assign s.ar_user   = m.ar_user  [int'(w_ar_sel)*USER_WIDTH +: USER_WIDTH];
    assign s.ar_valid  = (r_state == GRANT) && m.ar_valid[r_gnt];
    assign w_ar_hs     = s.ar_valid && s.ar_ready;

    always_comb begin
        m.ar_ready = '0;
        if (r_state == GRANT) begin
            m.ar_ready[r_gnt] = s.ar_ready;
        end
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state  <= IDLE;
            r_gnt    <= '0;
            r_rr_ptr <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_gnt    <= w_gnt_nxt;
            r_rr_ptr <= w_rr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_gnt_nxt   = r_gnt;
        w_rr_nxt    = r_rr_ptr;
        w_push      = 1'b0;
        case (r_state)
            IDLE: begin
                // Full is registered occupancy, so a pop while full only
                // opens the door for a grant on the following edge.
                if (w_any && !w_full) begin
                    w_gnt_nxt   = w_pick;
                    w_state_nxt = GRANT;
                end
            end
            GRANT: begin
                if (w_ar_hs) begin
                    w_push      = 1'b1;
                    w_state_nxt = IDLE;
                    w_rr_nxt    = (r_gnt == IDX_W'(N_MASTER - 1)) ? '0 : r_gnt + 1'b1;
                end
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    // ---------------- R channel ----------------
    // Payload is broadcast; only the head master sees valid.
    assign m.r_id   = {N_MASTER{s.r_id}};
    assign m.r_data = {N_MASTER{s.r_data}};
    assign m.r_resp = {N_MASTER{s.r_resp}};
    assign m.r_user = {N_MASTER{s.r_user}};
    assign s.r_ready = !w_empty && m.r_ready[w_head];
    assign w_pop     = s.r_valid && s.r_ready;

    always_comb begin
        m.r_valid = '0;
        if (!w_empty) begin
            m.r_valid[w_head] = s.r_valid;
        end
    end

    // ---------------- order FIFO ----------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < MAX_TRANSACTION; i++) begin
                r_fifo[i] <= '0;
            end
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_fifo[r_wr_ptr] <= r_gnt;
                r_wr_ptr <= (r_wr_ptr == PTR_W'(MAX_TRANSACTION - 1)) ? '0 : r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= (r_rd_ptr == PTR_W'(MAX_TRANSACTION - 1)) ? '0 : r_rd_ptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end
endmodule

// File: tb/tb_nasti_lite_read_arbiter.sv
module tb_nasti_lite_read_arbiter;
    localparam int N    = 2;
    localparam int MAXT = 2;
    localparam int IDW  = 1;
    localparam int AW   = 12;
    localparam int DW   = 32;
    localparam int UW   = 1;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    always #5 clk = ~clk;

    nasti_lite_read_arbiter_if #(.N(N), .ID_WIDTH(IDW), .ADDR_WIDTH(AW),
                                 .DATA_WIDTH(DW), .USER_WIDTH(UW)) u_m_if ();
    nasti_lite_read_arbiter_if #(.N(1), .ID_WIDTH(IDW), .ADDR_WIDTH(AW),
                                 .DATA_WIDTH(DW), .USER_WIDTH(UW)) u_s_if ();

    nasti_lite_read_arbiter #(
        .N_MASTER(N), .MAX_TRANSACTION(MAXT), .ID_WIDTH(IDW),
        .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .USER_WIDTH(UW)
    ) u_dut (
        .clk  (clk),
        .rstn (rstn),
        .m    (u_m_if),
        .s    (u_s_if)
    );

    int n_vec = 0;
    int n_err = 0;

    // stimulus knobs
    logic [N-1:0] req_mask = '0;
    int  p_req = 0, p_arrdy = 0, p_rval = 0, p_rrdy = 0;
    bit  stray = 0;
    bit  rst_req = 1;
    bit  addr_ovr = 0;
    bit  data_ovr = 0;

    // slave model and handshake records from the last sample point
    int  slv_q[$];
    bit  r_pend = 0;
    logic [N-1:0] hs_m = '0;
    bit  hs_r = 0;

    // reference model: pending grant (-1 = none), round-robin start, issue order
    int  mdl_gnt = -1;
    int  mdl_rr  = 0;
    int  mdl_order[$];

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic drive();
        rstn = !rst_req;
        if (!rstn) begin
            slv_q.delete();
            r_pend = 0;
            hs_r = 0;
            hs_m = '0;
        end
        for (int i = 0; i < N; i++) begin
            if (u_m_if.ar_valid[i] && !hs_m[i]) continue;
            if (req_mask[i] && ($urandom % 100) < p_req) begin
                u_m_if.ar_valid[i] = 1'b1;
                u_m_if.ar_id[i*IDW +: IDW]       = IDW'($urandom);
                u_m_if.ar_addr[i*AW +: AW]       = AW'($urandom);
                u_m_if.ar_prot[i*3 +: 3]         = 3'($urandom);
                u_m_if.ar_qos[i*4 +: 4]          = 4'($urandom);
                u_m_if.ar_region[i*4 +: 4]       = 4'($urandom);
                u_m_if.ar_user[i*UW +: UW]       = UW'($urandom);
                if (addr_ovr && i == 1) begin
                    u_m_if.ar_addr[i*AW +: AW] = AW'(12'h010);
                    addr_ovr = 0;
                end
            end else begin
                u_m_if.ar_valid[i] = 1'b0;
            end
        end
        u_s_if.ar_ready = (($urandom % 100) < p_arrdy);
        if (hs_r) begin
            if (slv_q.size() > 0) void'(slv_q.pop_front());
            r_pend = 0;
        end
        if (!r_pend) begin
            if (slv_q.size() > 0 && ($urandom % 100) < p_rval) begin
                u_s_if.r_valid = 1'b1;
                u_s_if.r_id    = IDW'(slv_q[0]);
                u_s_if.r_data  = data_ovr ? DW'(32'hDEADBEEF) : DW'($urandom);
                u_s_if.r_resp  = 2'($urandom);
                u_s_if.r_user  = UW'($urandom);
                data_ovr = 0;
                r_pend = 1;
            end else if (stray) begin
                u_s_if.r_valid = 1'b1;
                u_s_if.r_data  = DW'($urandom);
            end else begin
                u_s_if.r_valid = 1'b0;
            end
        end
        for (int i = 0; i < N; i++) u_m_if.r_ready[i] = (($urandom % 100) < p_rrdy);
    endtask

    task automatic check_outputs();
        int head;
        logic exp_arv;
        if (!rstn) begin
            mdl_gnt = -1;
            mdl_rr  = 0;
            mdl_order.delete();
        end
        exp_arv = (mdl_gnt >= 0) ? u_m_if.ar_valid[mdl_gnt] : 1'b0;
        check("s_ar_valid", 64'(u_s_if.ar_valid), 64'(exp_arv));
        if (exp_arv) begin
            check("s_ar_addr", 64'(u_s_if.ar_addr), 64'(u_m_if.ar_addr[mdl_gnt*AW +: AW]));
            check("s_ar_id", 64'(u_s_if.ar_id), 64'(u_m_if.ar_id[mdl_gnt*IDW +: IDW]));
            check("s_ar_qos", 64'(u_s_if.ar_qos), 64'(u_m_if.ar_qos[mdl_gnt*4 +: 4]));
        end
        for (int i = 0; i < N; i++)
            check($sformatf("m_ar_ready[%0d]", i), 64'(u_m_if.ar_ready[i]),
                  64'((mdl_gnt == i) ? u_s_if.ar_ready : 1'b0));
        head = (mdl_order.size() > 0) ? mdl_order[0] : -1;
        check("s_r_ready", 64'(u_s_if.r_ready), 64'((head >= 0) ? u_m_if.r_ready[head] : 1'b0));
        for (int i = 0; i < N; i++) begin
            check($sformatf("m_r_valid[%0d]", i), 64'(u_m_if.r_valid[i]),
                  64'((head == i) ? u_s_if.r_valid : 1'b0));
            if (head == i && u_s_if.r_valid) begin
                check($sformatf("m_r_data[%0d]", i), 64'(u_m_if.r_data[i*DW +: DW]), 64'(u_s_if.r_data));
                check($sformatf("m_r_id[%0d]", i), 64'(u_m_if.r_id[i*IDW +: IDW]), 64'(u_s_if.r_id));
            end
        end
        // record handshakes completing at the next edge (stimulus bookkeeping)
        hs_m = u_m_if.ar_valid & u_m_if.ar_ready;
        hs_r = u_s_if.r_valid && u_s_if.r_ready;
        if (u_s_if.ar_valid && u_s_if.ar_ready) slv_q.push_back(int'(u_s_if.ar_id));
    endtask

    task automatic model_step();
        bit ar_hs, pop, full;
        int head;
        if (!rstn) return;
        head  = (mdl_order.size() > 0) ? mdl_order[0] : -1;
        ar_hs = (mdl_gnt >= 0) && u_m_if.ar_valid[mdl_gnt] && u_s_if.ar_ready;
        pop   = (head >= 0) && u_s_if.r_valid && u_m_if.r_ready[head];
        full  = (mdl_order.size() == MAXT);
        if (mdl_gnt >= 0) begin
            if (ar_hs) begin
                mdl_order.push_back(mdl_gnt);
                mdl_rr  = (mdl_gnt + 1) % N;
                mdl_gnt = -1;
            end
        end else if (!full) begin
            for (int k = 0; k < N; k++) begin
                if (u_m_if.ar_valid[(mdl_rr + k) % N]) begin
                    mdl_gnt = (mdl_rr + k) % N;
                    break;
                end
            end
        end
        if (pop) void'(mdl_order.pop_front());
    endtask

    task automatic cycle();
        @(negedge clk);
        drive();
        #1;
        check_outputs();
        model_step();
    endtask

    task automatic run(input logic [N-1:0] mask, input int preq, input int parrdy,
                       input int prval, input int prrdy, input int ncyc);
        req_mask = mask; p_req = preq; p_arrdy = parrdy; p_rval = prval; p_rrdy = prrdy;
        repeat (ncyc) cycle();
    endtask

    initial begin
        u_m_if.ar_valid = '0; u_m_if.ar_id = '0; u_m_if.ar_addr = '0; u_m_if.ar_prot = '0;
        u_m_if.ar_qos = '0; u_m_if.ar_region = '0; u_m_if.ar_user = '0; u_m_if.r_ready = '0;
        u_s_if.ar_ready = '0; u_s_if.r_valid = '0; u_s_if.r_id = '0; u_s_if.r_data = '0;
        u_s_if.r_resp = '0; u_s_if.r_user = '0;

        // reset then idle
        run('0, 0, 0, 0, 0, 3);
        rst_req = 0;
        run('0, 0, 100, 100, 100, 3);

        // single master 1 request at 0x010, beat 0xDEADBEEF comes back on master 1
        addr_ovr = 1; data_ovr = 1;
        run(2'b10, 100, 100, 100, 100, 1);
        run(2'b00, 0, 100, 100, 100, 8);

        // both masters streaming: alternating grants, in-order returns
        run(2'b11, 100, 100, 100, 100, 20);

        // slave withholds R: FIFO fills, then pops release new grants
        run(2'b11, 100, 100, 0, 100, 12);
        run(2'b11, 100, 100, 100, 100, 6);

        // s_ar_ready low while both request: grant and payload held
        run(2'b11, 100, 0, 100, 100, 6);
        run(2'b11, 100, 100, 100, 100, 4);

        // head master back-pressures R
        run(2'b11, 100, 100, 100, 0, 4);
        run(2'b11, 100, 100, 100, 50, 20);

        // stray R with nothing outstanding is never delivered
        run('0, 0, 100, 100, 100, 10);
        stray = 1;
        run('0, 0, 100, 100, 100, 4);
        stray = 0;
        run('0, 0, 100, 100, 100, 2);

        // async reset with outstanding transactions and a live grant
        run(2'b11, 100, 100, 0, 100, 8);
        @(negedge clk);
        #2;
        rstn = 1'b0;
        rst_req = 1;
        #1;
        check_outputs();
        run(2'b11, 100, 100, 100, 100, 2);
        rst_req = 0;
        run(2'b11, 100, 100, 100, 100, 10);

        // randomized regime changes
        for (int ph = 0; ph < 40; ph++) begin
            run(N'($urandom), int'($urandom_range(20, 100)), int'($urandom_range(10, 100)),
                int'($urandom_range(10, 100)), int'($urandom_range(10, 100)), 50);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
